// File: rtl/aux_command_engines.sv
// Oscilloscope auxiliary engines: sawtooth fake ADC, sample-memory clearer and
// UART echo replayer. They share the UART status inputs, and every output is a register.
module aux_command_engines (
  input  logic       clk,
  input  logic       reset,
  input  logic       adc_tick,
  output logic [7:0] adc_data,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  input  logic       tx_active,
  input  logic       tx_done,
  input  logic       clr_activate,
  output logic       clr_done,
  output logic       clr_mem_clk,
  output logic       clr_mem_we,
  output logic [7:0] clr_mem_addr,
  output logic [7:0] clr_mem_data,
  input  logic       rep_activate,
  output logic       rep_done,
  output logic [7:0] rep_tx_data,
  output logic       rep_tx_start
);

  typedef enum logic [2:0] {
    C_IDLE      = 3'd0,
    C_WAIT_FILL = 3'd1,
    C_SETUP     = 3'd2,
    C_STROBE    = 3'd3,
    C_DONE      = 3'd4
  } clr_state_e;

  typedef enum logic [2:0] {
    R_IDLE      = 3'd0,
    R_WAIT_RX   = 3'd1,
    R_WAIT_TX   = 3'd2,
    R_START     = 3'd3,
    R_WAIT_DONE = 3'd4,
    R_DONE      = 3'd5
  } rep_state_e;

  logic [7:0] adc_q;
  logic [7:0] adc_d;

  clr_state_e clr_state_q;
  logic [7:0] clr_addr_q;
  logic [7:0] clr_fill_q;
  logic       clr_we_q;
  logic       clr_clk_q;
  logic       clr_done_q;

  rep_state_e rep_state_q;
  logic [7:0] rep_data_q;
  logic       rep_start_q;
  logic       rep_done_q;

  // Sawtooth next value; 8-bit arithmetic wraps 255 -> 0.
  always_comb begin
    if (adc_tick) begin
      adc_d = adc_q + 8'd1;
    end else begin
      adc_d = adc_q;
    end
  end

  // Fake ADC counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      adc_q <= 8'd0;
    end else begin
      adc_q <= adc_d;
    end
  end

  // Memory clearer FSM: outputs are registered alongside the state they belong to.
  always_ff @(posedge clk) begin
    if (reset || !clr_activate) begin
      clr_state_q <= C_IDLE;
      clr_addr_q  <= 8'd0;
      clr_fill_q  <= 8'd0;
      clr_we_q    <= 1'b0;
      clr_clk_q   <= 1'b0;
      clr_done_q  <= 1'b0;
    end else begin
      case (clr_state_q)
        C_IDLE: begin
          // An rx byte coinciding with activation is deliberately not taken as fill.
          clr_state_q <= C_WAIT_FILL;
        end
        C_WAIT_FILL: begin
          if (rx_ready) begin
            clr_fill_q  <= rx_data;
            clr_addr_q  <= 8'd0;
            clr_we_q    <= 1'b1;
            clr_clk_q   <= 1'b0;
            clr_state_q <= C_SETUP;
          end
        end
        C_SETUP: begin
          clr_clk_q   <= 1'b1;
          clr_state_q <= C_STROBE;
        end
        C_STROBE: begin
          clr_clk_q <= 1'b0;
          if (clr_addr_q == 8'hFF) begin
            clr_we_q    <= 1'b0;
            clr_done_q  <= 1'b1;
            clr_state_q <= C_DONE;
          end else begin
            clr_addr_q  <= clr_addr_q + 8'd1;
            clr_state_q <= C_SETUP;
          end
        end
        C_DONE: begin
          clr_state_q <= C_DONE;
        end
        default: begin
          clr_state_q <= C_IDLE;
        end
      endcase
    end
  end

  // Replayer FSM; the echoed byte survives deactivation and is only cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rep_state_q <= R_IDLE;
      rep_data_q  <= 8'd0;
      rep_start_q <= 1'b0;
      rep_done_q  <= 1'b0;
    end else if (!rep_activate) begin
      rep_state_q <= R_IDLE;
      rep_start_q <= 1'b0;
      rep_done_q  <= 1'b0;
    end else begin
      case (rep_state_q)
        R_IDLE: begin
          rep_state_q <= R_WAIT_RX;
        end
        R_WAIT_RX: begin
          if (rx_ready) begin
            rep_data_q  <= rx_data;
            rep_state_q <= R_WAIT_TX;
          end
        end
        R_WAIT_TX: begin
          if (!tx_active) begin
            rep_start_q <= 1'b1;
            rep_state_q <= R_START;
          end
        end
        R_START: begin
          rep_start_q <= 1'b0;
          rep_state_q <= R_WAIT_DONE;
        end
        R_WAIT_DONE: begin
          // tx_done is only honoured after our own start, so stale strobes are ignored.
          if (tx_done) begin
            rep_done_q  <= 1'b1;
            rep_state_q <= R_DONE;
          end
        end
        R_DONE: begin
          rep_state_q <= R_DONE;
        end
        default: begin
          rep_state_q <= R_IDLE;
        end
      endcase
    end
  end

  assign adc_data     = adc_q;
  assign clr_done     = clr_done_q;
  assign clr_mem_clk  = clr_clk_q;
  assign clr_mem_we   = clr_we_q;
  assign clr_mem_addr = clr_addr_q;
  assign clr_mem_data = clr_fill_q;
  assign rep_done     = rep_done_q;
  assign rep_tx_data  = rep_data_q;
  assign rep_tx_start = rep_start_q;

endmodule

// File: tb/tb_aux_command_engines.sv
// Scoreboard bench for aux_command_engines: stimulus tasks push time-stamped expected
// events, and a negedge monitor pops and compares them whenever the DUT shows activity.
module tb_aux_command_engines;

  logic       clk = 1'b0;
  logic       reset, adc_tick, rx_ready, tx_active, tx_done, clr_activate, rep_activate;
  logic [7:0] rx_data, adc_data, clr_mem_addr, clr_mem_data, rep_tx_data;
  logic       clr_done, clr_mem_clk, clr_mem_we, rep_done, rep_tx_start;

  always #10 clk = ~clk;

  aux_command_engines dut (
    .clk(clk), .reset(reset), .adc_tick(adc_tick), .adc_data(adc_data),
    .rx_data(rx_data), .rx_ready(rx_ready), .tx_active(tx_active), .tx_done(tx_done),
    .clr_activate(clr_activate), .clr_done(clr_done), .clr_mem_clk(clr_mem_clk),
    .clr_mem_we(clr_mem_we), .clr_mem_addr(clr_mem_addr), .clr_mem_data(clr_mem_data),
    .rep_activate(rep_activate), .rep_done(rep_done), .rep_tx_data(rep_tx_data),
    .rep_tx_start(rep_tx_start)
  );

  typedef struct { int cyc; logic [7:0] a; logic [7:0] d; } ev_t;
  typedef struct { int cyc; bit lvl; } lv_t;

  ev_t clr_exp[$];
  ev_t rep_exp[$];
  lv_t cdone_exp[$];
  lv_t rdone_exp[$];
  int  adc_exp[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  bit adc_rand = 1'b0;
  int adc_m = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic note_fail(input string name, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s: got %0h expected no event (cycle %0d)", name, act, cyc);
  endtask

  // Reference sawtooth: reset clears it, each tick adds one modulo 256.
  always @(posedge clk) begin
    int nxt;
    nxt = reset ? 0 : (adc_tick ? (adc_m + 1) % 256 : adc_m);
    if (mon_en && nxt != adc_m) adc_exp.push_back(nxt);
    adc_m <= nxt;
  end

  logic [7:0] adc_prev;
  logic       cdone_prev, rdone_prev;

  // Monitor: compares every DUT event against the front of its expectation queue.
  always @(negedge clk) begin
    ev_t e;
    lv_t l;
    if (mon_en) begin
      if (adc_data !== adc_prev) begin
        if (adc_exp.size() == 0) note_fail("adc_change", 32'(adc_data));
        else chk("adc_data", 32'(adc_data), 32'(adc_exp.pop_front()));
      end
      if (clr_mem_clk === 1'b1) begin
        if (clr_exp.size() == 0) note_fail("clr_strobe", 32'(clr_mem_addr));
        else begin
          e = clr_exp.pop_front();
          chk("clr_strobe_cycle", 32'(cyc), 32'(e.cyc));
          chk("clr_strobe_addr", 32'(clr_mem_addr), 32'(e.a));
          chk("clr_strobe_data", 32'(clr_mem_data), 32'(e.d));
          chk("clr_strobe_we", 32'(clr_mem_we), 32'd1);
        end
      end
      if (rep_tx_start === 1'b1) begin
        if (rep_exp.size() == 0) note_fail("rep_start", 32'(rep_tx_data));
        else begin
          e = rep_exp.pop_front();
          chk("rep_start_cycle", 32'(cyc), 32'(e.cyc));
          chk("rep_tx_data", 32'(rep_tx_data), 32'(e.d));
          chk("rep_start_tx_idle", 32'(tx_active), 32'd0);
        end
      end
      if (clr_done !== cdone_prev) begin
        if (cdone_exp.size() == 0) note_fail("clr_done_change", 32'(clr_done));
        else begin
          l = cdone_exp.pop_front();
          chk("clr_done_cycle", 32'(cyc), 32'(l.cyc));
          chk("clr_done_level", 32'(clr_done), 32'(l.lvl));
        end
      end
      if (rep_done !== rdone_prev) begin
        if (rdone_exp.size() == 0) note_fail("rep_done_change", 32'(rep_done));
        else begin
          l = rdone_exp.pop_front();
          chk("rep_done_cycle", 32'(cyc), 32'(l.cyc));
          chk("rep_done_level", 32'(rep_done), 32'(l.lvl));
        end
      end
    end
    adc_prev   <= adc_data;
    cdone_prev <= clr_done;
    rdone_prev <= rep_done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (adc_rand) adc_tick = 1'($urandom_range(0, 1));
  endtask

  task automatic chk_all_zero(input string name);
    @(negedge clk);
    chk(name, {adc_data, clr_mem_addr, clr_mem_data, rep_tx_data,
               clr_done, clr_mem_clk, clr_mem_we, rep_done, rep_tx_start}, 32'd0);
  endtask

  // Clear with a fill byte; the engine input goes inactive in cycle t+hold (t = fill rx cycle).
  task automatic run_clear(input logic [7:0] fill, input int hold, input bit use_rst);
    int t;
    clr_activate = 1'b1; rx_ready = 1'b1; rx_data = ~fill;
    tick();
    rx_ready = 1'b0;
    repeat ($urandom_range(1, 4)) tick();
    rx_ready = 1'b1; rx_data = fill; t = cyc;
    // Address a is strobed in cycle t+2+2a; done rises at t+513.
    for (int a = 0; a < 256; a++)
      if (2 + 2 * a <= hold) clr_exp.push_back('{t + 2 + 2 * a, 8'(a), fill});
    if (hold >= 513) begin
      cdone_exp.push_back('{t + 513, 1'b1});
      cdone_exp.push_back('{t + hold + 1, 1'b0});
    end
    tick();
    rx_ready = 1'b0;
    while (cyc < t + hold) tick();
    if (use_rst) reset = 1'b1;
    else clr_activate = 1'b0;
    tick();
    reset = 1'b0; clr_activate = 1'b0;
    if (use_rst) chk_all_zero("clr_reset_outputs");
    else begin
      @(negedge clk);
      chk("clr_idle_outputs", {clr_done, clr_mem_clk, clr_mem_we, clr_mem_addr, clr_mem_data}, 32'd0);
    end
    repeat (3) tick();
  endtask

  // Echo one byte; transmitter busy for cycles t+1..t+busy; tx_done dly cycles after start.
  task automatic run_rep(input logic [7:0] data, input int busy, input int dly, input int rst_at);
    int t, s, f;
    rep_activate = 1'b1; rx_ready = 1'b1; rx_data = ~data;
    tick();
    rx_ready = 1'b0;
    repeat ($urandom_range(1, 3)) tick();
    rx_ready = 1'b1; rx_data = data; tx_active = (busy > 0); t = cyc;
    s = t + busy + 2;
    if (rst_at == 0) begin
      rep_exp.push_back('{s, 8'd0, data});
      rdone_exp.push_back('{s + dly + 1, 1'b1});
    end
    tick();
    rx_ready = 1'b0;
    if (busy > 0) begin
      // A stale tx_done and a second rx byte while waiting must both be ignored.
      tx_done = 1'b1; rx_ready = 1'b1; rx_data = data ^ 8'h3C;
      tick();
      tx_done = 1'b0; rx_ready = 1'b0;
    end
    while (cyc < t + busy + 1) begin
      if (rst_at > 0 && cyc == t + rst_at) begin
        reset = 1'b1;
        tick();
        reset = 1'b0; rep_activate = 1'b0; tx_active = 1'b0;
        chk_all_zero("rep_reset_outputs");
        repeat (2) tick();
        return;
      end
      tick();
    end
    tx_active = 1'b0;
    while (cyc < s + 1) tick();
    tx_active = 1'b1;
    while (cyc < s + dly) tick();
    tx_done = 1'b1; tx_active = 1'b0;
    tick();
    tx_done = 1'b0;
    repeat ($urandom_range(1, 6)) tick();
    rep_activate = 1'b0; f = cyc;
    rdone_exp.push_back('{f + 1, 1'b0});
    tick();
    repeat (3) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; adc_tick = 1'b0; rx_ready = 1'b0; rx_data = 8'd0; tx_active = 1'b0;
    tx_done = 1'b0; clr_activate = 1'b0; rep_activate = 1'b0;
    tick();
    tick();
    chk_all_zero("reset_outputs");
    tick();
    reset = 1'b0;
    mon_en = 1'b1;

    // Directed sawtooth: 300 ticks wrap once, then the value must hold.
    adc_tick = 1'b1;
    repeat (300) tick();
    adc_tick = 1'b0;
    tick();
    @(negedge clk);
    chk("adc_after_300", 32'(adc_data), 32'(300 % 256));
    repeat (20) tick();
    @(negedge clk);
    chk("adc_hold", 32'(adc_data), 32'(300 % 256));

    adc_rand = 1'b1;
    run_clear(8'h00, 520, 1'b0);
    run_clear(8'hA5, 22, 1'b0);
    run_rep(8'h5A, 0, 100, 0);
    run_rep(8'($urandom), 50, $urandom_range(2, 40), 0);
    run_rep(8'($urandom), 30, 10, 12);
    run_rep(8'($urandom), $urandom_range(1, 20), $urandom_range(2, 40), 0);
    run_clear(8'($urandom), $urandom_range(100, 400), 1'b1);
    run_clear(8'($urandom), 530, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_clear(8'($urandom), $urandom_range(20, 60), 1'b0);
      run_rep(8'($urandom), $urandom_range(0, 15), $urandom_range(2, 20), 0);
    end

    adc_rand = 1'b0; adc_tick = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    chk("clr_events_left", 32'(clr_exp.size()), 32'd0);
    chk("rep_events_left", 32'(rep_exp.size()), 32'd0);
    chk("clr_done_events_left", 32'(cdone_exp.size()), 32'd0);
    chk("rep_done_events_left", 32'(rdone_exp.size()), 32'd0);
    chk("adc_events_left", 32'(adc_exp.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
